// File: rtl/shift_rotate_unit.sv
// Multi-bit shift/rotate register with carry flag: executes one bit-step per clock
// for a commanded amount, using a start/busy/done handshake.
module shift_rotate_unit #(
  parameter int unsigned Width = 8,
  parameter int unsigned CntW  = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_data_i,
  input  logic             cf_i,
  input  logic             start_i,
  input  logic [2:0]       mode_i,
  input  logic [CntW-1:0]  amount_i,
  output logic [Width-1:0] out_o,
  output logic             cf_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             zero_o
);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  localparam logic [2:0] ModeRol = 3'b000;
  localparam logic [2:0] ModeRor = 3'b001;
  localparam logic [2:0] ModeRcl = 3'b010;
  localparam logic [2:0] ModeRcr = 3'b011;
  localparam logic [2:0] ModeShl = 3'b100;
  localparam logic [2:0] ModeShr = 3'b101;
  localparam logic [2:0] ModeSar = 3'b110;

  state_e            state_q;
  logic [Width-1:0]  out_q;
  logic              cf_q;
  logic              busy_q;
  logic              done_q;
  logic [2:0]        mode_q;
  logic [CntW-1:0]   cnt_q;

  logic [Width-1:0]  step_out;
  logic              step_cf;

  // One single-bit step of the latched mode, always computed from the current out/cf.
  always_comb begin
    step_out = out_q;
    step_cf  = cf_q;
    case (mode_q)
      ModeRol: begin
        step_out = {out_q[Width-2:0], out_q[Width-1]};
        step_cf  = out_q[Width-1];
      end
      ModeRor: begin
        step_out = {out_q[0], out_q[Width-1:1]};
        step_cf  = out_q[0];
      end
      ModeRcl: begin
        step_out = {out_q[Width-2:0], cf_q};
        step_cf  = out_q[Width-1];
      end
      ModeRcr: begin
        step_out = {cf_q, out_q[Width-1:1]};
        step_cf  = out_q[0];
      end
      ModeShl: begin
        step_out = {out_q[Width-2:0], 1'b0};
        step_cf  = out_q[Width-1];
      end
      ModeShr: begin
        step_out = {1'b0, out_q[Width-1:1]};
        step_cf  = out_q[0];
      end
      ModeSar: begin
        step_out = {out_q[Width-1], out_q[Width-1:1]};
        step_cf  = out_q[0];
      end
      default: begin
        step_out = out_q;
        step_cf  = cf_q;
      end
    endcase
  end

  // Priority: reset, load, start, shift step. done is a single-cycle pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      out_q   <= '0;
      cf_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= 3'b000;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (load_i) begin
        out_q   <= load_data_i;
        cf_q    <= cf_i;
        state_q <= StIdle;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (start_i) begin
              mode_q <= mode_i;
              if (amount_i == '0) begin
                done_q <= 1'b1;
              end else begin
                cnt_q   <= amount_i;
                state_q <= StShift;
                busy_q  <= 1'b1;
              end
            end
          end
          StShift: begin
            out_q <= step_out;
            cf_q  <= step_cf;
            cnt_q <= cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          default: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out_o  = out_q;
  assign cf_o   = cf_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign zero_o = (out_q == '0);

endmodule
